// File: rtl/shift_chain_sched.sv
// shift_chain_sched: round-robin two-requester serializer feeding a free-running DEPTH-stage shift chain, with per-word completion tracking
//   clk, rst_n                     : clock, synchronous active-low reset
//   req{0,1}_valid/_data/_ready    : parallel word requesters; ready = word accepted this cycle
//   ser_bit/_active/_first/_last   : registered serial stream (MSB first) into chain stage 0
//   done, done_id                  : pulse when a word's LSB reaches the final stage, and its owner
module shift_chain_sched #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_bit,
  output logic             ser_active,
  output logic             ser_first,
  output logic             ser_last,
  output logic             done,
  output logic             done_id
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             owner_q, owner_d, rr_q, rr_d;
  logic             ser_bit_q, ser_bit_d, ser_active_q, ser_active_d;
  logic             ser_first_q, ser_first_d, ser_last_q, ser_last_d;
  logic [DEPTH-1:0] trk_last_q, trk_last_d, trk_id_q, trk_id_d;
  logic             done_id_q, done_id_d;
  logic             window, grant, accept;
  always_comb begin
    window     = rst_n && (state_q == IDLE || ser_last_q);
    grant      = (req0_valid && req1_valid) ? rr_q : req1_valid;
    accept     = window && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      word_d  = grant ? req1_data : req0_data;
      owner_d = grant;
      rr_d    = !grant;
    end else if (state_q == SHIFT) begin
      state_d = (cnt_q == CMAX) ? IDLE : SHIFT;
      cnt_d   = cnt_q + CW'(1);
      word_d  = word_q << 1;
    end
    // word_d is left-aligned so the bit on the wire next cycle is always its MSB
    ser_active_d = (state_d == SHIFT);
    ser_bit_d    = ser_active_d && word_d[WIDTH-1];
    ser_first_d  = ser_active_d && cnt_d == '0;
    ser_last_d   = ser_active_d && cnt_d == CMAX;
    // tracking stage 0 pairs with the bit currently entering chain stage 0
    trk_last_d[0] = ser_last_q;
    trk_id_d[0]   = owner_q;
    for (int i = 1; i < DEPTH; i++) begin
      trk_last_d[i] = trk_last_q[i-1];
      trk_id_d[i]   = trk_id_q[i-1];
    end
    done_id_d = trk_last_d[DEPTH-1] ? trk_id_d[DEPTH-1] : done_id_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      ser_bit_q    <= 1'b0;
      ser_active_q <= 1'b0;
      ser_first_q  <= 1'b0;
      ser_last_q   <= 1'b0;
      trk_last_q   <= '0;
      trk_id_q     <= '0;
      done_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      ser_bit_q    <= ser_bit_d;
      ser_active_q <= ser_active_d;
      ser_first_q  <= ser_first_d;
      ser_last_q   <= ser_last_d;
      trk_last_q   <= trk_last_d;
      trk_id_q     <= trk_id_d;
      done_id_q    <= done_id_d;
    end
  end
  assign ser_bit    = ser_bit_q;
  assign ser_active = ser_active_q;
  assign ser_first  = ser_first_q;
  assign ser_last   = ser_last_q;
  assign done       = trk_last_q[DEPTH-1];
  assign done_id    = done_id_q;
endmodule
